// File: rtl/usb_host_decoder_pkg.sv
// Shared constants and types for the host-side game-pad link decoder.
// Button code map, default code widths, serial receiver state encoding.
package usb_host_pkg;

  localparam int unsigned CORD_W_DEF = 8;
  localparam int unsigned OP_W_DEF   = 4;

  localparam logic [7:0] CORD_L = 8'hC1;
  localparam logic [7:0] CORD_R = 8'hC2;
  localparam logic [7:0] CORD_U = 8'hC4;
  localparam logic [7:0] CORD_D = 8'hC8;

  localparam logic [3:0] OP_A = 4'h1;
  localparam logic [3:0] OP_B = 4'h2;
  localparam logic [3:0] OP_X = 4'h4;
  localparam logic [3:0] OP_Y = 4'h8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_STOP  = 2'd2
  } rx_state_e;

  // One cycle's worth of decoded events, registered as a unit in the top.
  typedef struct packed {
    logic l;
    logic r;
    logic u;
    logic d;
    logic a;
    logic b;
    logic x;
    logic y;
    logic cord_valid;
    logic op_valid;
    logic frame_err;
  } evt_t;

endpackage

// File: rtl/usb_host_decoder_serial_rx.sv
// Serial frame receiver: start bit 1, W data bits MSB-first, stop bit 0.
// Pulses done with the captured word, or stop_err when the stop bit is 1.
module usb_serial_rx
  import usb_host_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         line,
  output logic [W-1:0] data,
  output logic         done,
  output logic         stop_err
);

  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  rx_state_e        state;
  rx_state_e        state_next;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     shreg;
  logic             shift_c;
  logic             stop_c;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (line) state_next = RX_SHIFT;
      RX_SHIFT: if (cnt == CNT_W'(W - 1)) state_next = RX_STOP;
      RX_STOP:  state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    shift_c = (state == RX_SHIFT);
    stop_c  = (state == RX_STOP);
  end

  // Datapath: clear aborts any partial word without reporting anything.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt      <= '0;
      shreg    <= '0;
      data     <= '0;
      done     <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      stop_err <= 1'b0;
      if (state == RX_IDLE) begin
        cnt <= '0;
      end
      if (shift_c) begin
        shreg <= W'({shreg, line});
        cnt   <= cnt + CNT_W'(1);
      end
      if (stop_c) begin
        if (!line) begin
          data <= shreg;
          done <= 1'b1;
        end else begin
          stop_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/usb_host_decoder.sv
// Host-side game-pad decoder: parallel codes (mode 0) or serial frames (mode 1)
// turned into one-cycle button pulses with valid and error flags.
module usb_host_decoder
  import usb_host_pkg::*;
#(
  parameter int unsigned CORD_W = CORD_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [CORD_W-1:0] in_cordinate_P,
  input  logic [OP_W-1:0]   in_operation_P,
  input  logic              in_cordinate_S,
  input  logic              in_operation_S,
  output logic              L,
  output logic              R,
  output logic              U,
  output logic              D,
  output logic              A,
  output logic              B,
  output logic              X,
  output logic              Y,
  output logic              cord_valid,
  output logic              op_valid,
  output logic              frame_err
);

  logic              mode_q;
  logic              mode_chg_c;
  logic              rx_clear_c;
  logic [CORD_W-1:0] prev_cord;
  logic [OP_W-1:0]   prev_op;

  logic [CORD_W-1:0] rx_cord_data;
  logic              rx_cord_done;
  logic              rx_cord_err;
  logic [OP_W-1:0]   rx_op_data;
  logic              rx_op_done;
  logic              rx_op_err;

  logic [CORD_W-1:0] cord_code_c;
  logic              cord_hit_c;
  logic              cord_stop_err_c;
  logic [OP_W-1:0]   op_code_c;
  logic              op_hit_c;
  logic              op_stop_err_c;

  evt_t evt_c;
  evt_t evt_q;

  // Any edge where mode differs from last cycle aborts everything in flight.
  assign mode_chg_c = mode ^ mode_q;
  assign rx_clear_c = mode_chg_c | ~mode;

  always_ff @(posedge clk) begin
    mode_q <= mode;
  end

  always_ff @(posedge clk) begin
    if (reset || mode_chg_c || mode) begin
      prev_cord <= '0;
      prev_op   <= '0;
    end else begin
      prev_cord <= in_cordinate_P;
      prev_op   <= in_operation_P;
    end
  end

  usb_serial_rx #(.W(CORD_W)) u_rx_cord (
    .clk      (clk),
    .reset    (reset),
    .clear    (rx_clear_c),
    .line     (in_cordinate_S),
    .data     (rx_cord_data),
    .done     (rx_cord_done),
    .stop_err (rx_cord_err)
  );

  usb_serial_rx #(.W(OP_W)) u_rx_op (
    .clk      (clk),
    .reset    (reset),
    .clear    (rx_clear_c),
    .line     (in_operation_S),
    .data     (rx_op_data),
    .done     (rx_op_done),
    .stop_err (rx_op_err)
  );

  // Per-channel event source: edge-detected parallel code or completed frame.
  always_comb begin
    cord_code_c     = in_cordinate_P;
    cord_hit_c      = 1'b0;
    cord_stop_err_c = 1'b0;
    op_code_c       = in_operation_P;
    op_hit_c        = 1'b0;
    op_stop_err_c   = 1'b0;
    if (mode) begin
      cord_code_c     = rx_cord_data;
      cord_hit_c      = rx_cord_done && (rx_cord_data != '0);
      cord_stop_err_c = rx_cord_err;
      op_code_c       = rx_op_data;
      op_hit_c        = rx_op_done && (rx_op_data != '0);
      op_stop_err_c   = rx_op_err;
    end else begin
      cord_hit_c = (in_cordinate_P != '0) && (in_cordinate_P != prev_cord);
      op_hit_c   = (in_operation_P != '0) && (in_operation_P != prev_op);
    end
  end

  always_comb begin
    evt_c            = '0;
    evt_c.l          = cord_hit_c && (cord_code_c == CORD_W'(CORD_L));
    evt_c.r          = cord_hit_c && (cord_code_c == CORD_W'(CORD_R));
    evt_c.u          = cord_hit_c && (cord_code_c == CORD_W'(CORD_U));
    evt_c.d          = cord_hit_c && (cord_code_c == CORD_W'(CORD_D));
    evt_c.a          = op_hit_c && (op_code_c == OP_W'(OP_A));
    evt_c.b          = op_hit_c && (op_code_c == OP_W'(OP_B));
    evt_c.x          = op_hit_c && (op_code_c == OP_W'(OP_X));
    evt_c.y          = op_hit_c && (op_code_c == OP_W'(OP_Y));
    evt_c.cord_valid = evt_c.l | evt_c.r | evt_c.u | evt_c.d;
    evt_c.op_valid   = evt_c.a | evt_c.b | evt_c.x | evt_c.y;
    evt_c.frame_err  = (cord_hit_c && !evt_c.cord_valid) || cord_stop_err_c
                    || (op_hit_c && !evt_c.op_valid) || op_stop_err_c;
  end

  always_ff @(posedge clk) begin
    if (reset || mode_chg_c) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_c;
    end
  end

  assign L          = evt_q.l;
  assign R          = evt_q.r;
  assign U          = evt_q.u;
  assign D          = evt_q.d;
  assign A          = evt_q.a;
  assign B          = evt_q.b;
  assign X          = evt_q.x;
  assign Y          = evt_q.y;
  assign cord_valid = evt_q.cord_valid;
  assign op_valid   = evt_q.op_valid;
  assign frame_err  = evt_q.frame_err;

endmodule

// File: tb/tb_usb_host_decoder.sv
// Directed bench for usb_host_decoder: vector table plus serial corner sequences.
// Observed bundle order: {L,R,U,D,A,B,X,Y,cord_valid,op_valid,frame_err}.
module tb_usb_host_decoder;

  localparam logic [10:0] E_0  = 11'h000;
  localparam logic [10:0] E_L  = 11'h400;
  localparam logic [10:0] E_R  = 11'h200;
  localparam logic [10:0] E_U  = 11'h100;
  localparam logic [10:0] E_D  = 11'h080;
  localparam logic [10:0] E_A  = 11'h040;
  localparam logic [10:0] E_B  = 11'h020;
  localparam logic [10:0] E_X  = 11'h010;
  localparam logic [10:0] E_Y  = 11'h008;
  localparam logic [10:0] E_CV = 11'h004;
  localparam logic [10:0] E_OV = 11'h002;
  localparam logic [10:0] E_FE = 11'h001;

  typedef struct {
    logic        mode;
    logic [7:0]  cp;
    logic [3:0]  op;
    logic        cs;
    logic        os;
    logic [10:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [7:0] in_cordinate_P;
  logic [3:0] in_operation_P;
  logic       in_cordinate_S;
  logic       in_operation_S;
  logic       L, R, U, D, A, B, X, Y;
  logic       cord_valid, op_valid, frame_err;
  logic [10:0] obs;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  usb_host_decoder dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .in_cordinate_P (in_cordinate_P),
    .in_operation_P (in_operation_P),
    .in_cordinate_S (in_cordinate_S),
    .in_operation_S (in_operation_S),
    .L              (L),
    .R              (R),
    .U              (U),
    .D              (D),
    .A              (A),
    .B              (B),
    .X              (X),
    .Y              (Y),
    .cord_valid     (cord_valid),
    .op_valid       (op_valid),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  assign obs = {L, R, U, D, A, B, X, Y, cord_valid, op_valid, frame_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [10:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  function automatic void add(input logic m, input logic [7:0] cp, input logic [3:0] op,
                              input logic cs, input logic os, input logic [10:0] exp);
    vec_t v;
    v = '{m, cp, op, cs, os, exp};
    vecs.push_back(v);
  endfunction

  // Drive one full frame on a serial line; outputs must stay quiet until W+2 edges after start.
  task automatic serial_frame(input bit on_cord, input logic [7:0] val, input int w,
                              input logic [10:0] exp, input string name);
    logic [7:0] v;
    v = val;
    if (on_cord) in_cordinate_S = 1'b1; else in_operation_S = 1'b1;
    tick(); chk({name, "_start"}, E_0);
    for (int i = w - 1; i >= 0; i--) begin
      if (on_cord) in_cordinate_S = v[i]; else in_operation_S = v[i];
      tick(); chk({name, "_data"}, E_0);
    end
    if (on_cord) in_cordinate_S = 1'b0; else in_operation_S = 1'b0;
    tick(); chk({name, "_stop"}, E_0);
    tick(); chk({name, "_event"}, exp);
    tick(); chk({name, "_after"}, E_0);
  endtask

  task automatic quiet(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick(); chk(name, E_0);
    end
  endtask

  initial begin
    // Parallel mode: edge detection, hold, change, unknown codes, dual channel.
    add(0, 8'hC1, 4'h0, 0, 0, E_L | E_CV);
    add(0, 8'hC1, 4'h0, 0, 0, E_0);
    add(0, 8'hC1, 4'h0, 0, 0, E_0);
    add(0, 8'hC1, 4'h0, 0, 0, E_0);
    add(0, 8'h00, 4'h0, 0, 0, E_0);
    add(0, 8'h00, 4'h2, 0, 0, E_B | E_OV);
    add(0, 8'h00, 4'h8, 0, 0, E_Y | E_OV);
    add(0, 8'h00, 4'h8, 0, 0, E_0);
    add(0, 8'h55, 4'h0, 0, 0, E_FE);
    add(0, 8'h55, 4'h0, 0, 0, E_0);
    add(0, 8'hC2, 4'h4, 0, 0, E_R | E_X | E_CV | E_OV);
    add(0, 8'hC4, 4'h3, 0, 0, E_U | E_CV | E_FE);
    add(0, 8'h00, 4'h0, 0, 0, E_0);
    add(0, 8'hC8, 4'h1, 0, 0, E_D | E_A | E_CV | E_OV);
    add(0, 8'h00, 4'h0, 0, 0, E_0);
    // Switch to serial (parallel inputs ignored), coordinate frame C4.
    add(1, 8'hC8, 4'h0, 0, 0, E_0);
    add(1, 8'hC8, 4'h0, 1, 0, E_0);
    add(1, 8'hC8, 4'h0, 1, 0, E_0);
    add(1, 8'hC8, 4'h0, 1, 0, E_0);
    add(1, 8'hC8, 4'h0, 0, 0, E_0);
    add(1, 8'hC8, 4'h0, 0, 0, E_0);
    add(1, 8'hC8, 4'h0, 0, 0, E_0);
    add(1, 8'hC8, 4'h0, 1, 0, E_0);
    add(1, 8'hC8, 4'h0, 0, 0, E_0);
    add(1, 8'hC8, 4'h0, 0, 0, E_0);
    add(1, 8'hC8, 4'h0, 0, 0, E_0);
    add(1, 8'hC8, 4'h0, 0, 0, E_U | E_CV);
    add(1, 8'hC8, 4'h0, 0, 0, E_0);
    // Operation frame 4'h1 with bad stop, then back-to-back frame 4'h4.
    add(1, 8'h00, 4'h0, 0, 1, E_0);
    add(1, 8'h00, 4'h0, 0, 0, E_0);
    add(1, 8'h00, 4'h0, 0, 0, E_0);
    add(1, 8'h00, 4'h0, 0, 0, E_0);
    add(1, 8'h00, 4'h0, 0, 1, E_0);
    add(1, 8'h00, 4'h0, 0, 1, E_0);
    add(1, 8'h00, 4'h0, 0, 1, E_FE);
    add(1, 8'h00, 4'h0, 0, 0, E_0);
    add(1, 8'h00, 4'h0, 0, 1, E_0);
    add(1, 8'h00, 4'h0, 0, 0, E_0);
    add(1, 8'h00, 4'h0, 0, 0, E_0);
    add(1, 8'h00, 4'h0, 0, 0, E_0);
    add(1, 8'h00, 4'h0, 0, 0, E_X | E_OV);
    // Both lines start together: C8 and 4'h2; op event lands 4 cycles earlier.
    add(1, 8'h00, 4'h0, 1, 1, E_0);
    add(1, 8'h00, 4'h0, 1, 0, E_0);
    add(1, 8'h00, 4'h0, 1, 0, E_0);
    add(1, 8'h00, 4'h0, 0, 1, E_0);
    add(1, 8'h00, 4'h0, 0, 0, E_0);
    add(1, 8'h00, 4'h0, 1, 0, E_0);
    add(1, 8'h00, 4'h0, 0, 0, E_B | E_OV);
    add(1, 8'hC1, 4'h0, 0, 0, E_0);
    add(1, 8'hC1, 4'h0, 0, 0, E_0);
    add(1, 8'hC1, 4'h0, 0, 0, E_0);
    add(1, 8'hC1, 4'h0, 0, 0, E_D | E_CV);
    // Back to parallel with C1 held across the switch: exactly one L.
    add(0, 8'hC1, 4'h0, 0, 0, E_0);
    add(0, 8'hC1, 4'h0, 0, 0, E_L | E_CV);
    add(0, 8'hC1, 4'h0, 0, 0, E_0);
    add(0, 8'h00, 4'h0, 0, 0, E_0);

    reset = 1'b1; mode = 1'b0;
    in_cordinate_P = '0; in_operation_P = '0;
    in_cordinate_S = 1'b0; in_operation_S = 1'b0;
    tick(); tick();
    chk("reset_state", E_0);
    in_cordinate_P = 8'hC1;
    tick(); chk("reset_suppress", E_0);
    in_cordinate_P = 8'h00;
    reset = 1'b0;
    tick(); chk("reset_release", E_0);

    foreach (vecs[i]) begin
      mode           = vecs[i].mode;
      in_cordinate_P = vecs[i].cp;
      in_operation_P = vecs[i].op;
      in_cordinate_S = vecs[i].cs;
      in_operation_S = vecs[i].os;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset after 3 data bits of a C2 frame: silent abort, then a clean frame.
    mode = 1'b1; in_cordinate_S = 1'b0;
    tick(); chk("rst_mode_sw", E_0);
    in_cordinate_S = 1'b1; tick(); chk("rst_start", E_0);
    in_cordinate_S = 1'b1; tick(); chk("rst_bit7", E_0);
    in_cordinate_S = 1'b1; tick(); chk("rst_bit6", E_0);
    in_cordinate_S = 1'b0; tick(); chk("rst_bit5", E_0);
    reset = 1'b1;
    tick(); chk("rst_mid", E_0);
    reset = 1'b0;
    quiet(12, "rst_quiet");
    serial_frame(1'b1, 8'hC2, 8, E_R | E_CV, "rst_next");

    // Mode toggle after 3 data bits of an op frame: silent abort, then Y.
    in_operation_S = 1'b1; tick(); chk("tog_start", E_0);
    in_operation_S = 1'b0; tick(); chk("tog_bit3", E_0);
    in_operation_S = 1'b1; tick(); chk("tog_bit2", E_0);
    in_operation_S = 1'b0; tick(); chk("tog_bit1", E_0);
    mode = 1'b0;
    tick(); chk("tog_to_par", E_0);
    mode = 1'b1;
    tick(); chk("tog_to_ser", E_0);
    quiet(8, "tog_quiet");
    serial_frame(1'b0, 8'h08, 4, E_Y | E_OV, "tog_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
